// File: rtl/sync_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Shared types and constants for the synchronized round-robin arbiter.
//   - arb_state_t : arbiter FSM states
//   - HOLD_W      : width of the grant hold counter
//   - id_width()  : grant index width for a given requester count
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int HOLD_W = 8;

    // Width of grant_id; at least one bit even for two requesters.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_rr_arbiter_sync_low.sv
// -----------------------------------------------------------------------------
// sync_low
//   Two-flop synchronizer with asynchronous active-low reset to 0.
//   Ports:
//     clk      in  system clock
//     n_rst    in  asynchronous active-low reset
//     async_in in  raw asynchronous level
//     sync_out out level delayed by two clk edges
// -----------------------------------------------------------------------------
module sync_low (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic sync_out
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

    assign sync_out = r_sync;

endmodule

// File: rtl/sync_rr_arbiter.sv
// -----------------------------------------------------------------------------
// sync_rr_arbiter
//   Round-robin arbiter for NUM_REQ asynchronous requesters. Each request is
//   synchronized, then a registered FSM (IDLE -> GRANT -> GAP) issues one-hot
//   grants. A grant held for MAX_HOLD cycles is revoked and that requester is
//   locked out until it drops and re-raises its request.
//   Ports:
//     clk         in  system clock
//     n_rst       in  asynchronous active-low reset
//     async_req   in  raw requests [NUM_REQ]
//     grant       out one-hot registered grant [NUM_REQ]
//     grant_valid out high while any grant bit is high
//     grant_id    out index of granted requester, 0 when idle
//     timeout     out one-cycle pulse on forced revoke
// -----------------------------------------------------------------------------
module sync_rr_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int MAX_HOLD = 16,
    localparam int ID_W     = id_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [NUM_REQ-1:0] async_req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               timeout
);

    // ---------------------------------------------------------------- sync
    logic [NUM_REQ-1:0] w_req_s;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_sync
            sync_low u_sync (
                .clk      (clk),
                .n_rst    (n_rst),
                .async_in (async_req[g]),
                .sync_out (w_req_s[g])
            );
        end
    endgenerate

    // ---------------------------------------------------------------- state
    arb_state_t         r_state,   w_state_nxt;
    logic [NUM_REQ-1:0] r_grant,   w_grant_nxt;
    logic [ID_W-1:0]    r_id,      w_id_nxt;
    logic [ID_W-1:0]    r_ptr,     w_ptr_nxt;
    logic [HOLD_W-1:0]  r_hold,    w_hold_nxt;
    logic [NUM_REQ-1:0] r_lock,    w_lock_nxt;
    logic               r_timeout, w_timeout_nxt;

    logic [NUM_REQ-1:0] w_elig;
    logic [ID_W:0]      w_pick;    // {found, index}
    logic [ID_W-1:0]    w_ptr_adv;

    // First set bit at or after ptr, wrapping. Scanning from the far end and
    // overwriting leaves the closest match to ptr as the result.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [ID_W-1:0]    ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) res = {1'b1, ID_W'(idx)};
        end
        return res;
    endfunction

    assign w_elig    = w_req_s & ~r_lock;
    assign w_pick    = rr_pick(w_elig, r_ptr);
    assign w_ptr_adv = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_id_nxt      = r_id;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;
        // A lock survives only while its requester keeps the line high.
        w_lock_nxt    = r_lock & w_req_s;

        case (r_state)
            IDLE: begin
                if (w_pick[ID_W]) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = NUM_REQ'(1) << w_pick[ID_W-1:0];
                    w_id_nxt    = w_pick[ID_W-1:0];
                    w_hold_nxt  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!w_req_s[r_id]) begin
                    w_state_nxt = GAP;
                    w_grant_nxt = '0;
                    w_id_nxt    = '0;
                    w_ptr_nxt   = w_ptr_adv;
                    w_hold_nxt  = '0;
                end else if (r_hold == HOLD_W'(MAX_HOLD)) begin
                    w_state_nxt      = GAP;
                    w_grant_nxt      = '0;
                    w_id_nxt         = '0;
                    w_ptr_nxt        = w_ptr_adv;
                    w_hold_nxt       = '0;
                    w_timeout_nxt    = 1'b1;
                    w_lock_nxt[r_id] = 1'b1;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            GAP: begin
                // Dead cycle keeps consecutive owners from overlapping.
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_id_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_id      <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_lock    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_id      <= w_id_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold    <= w_hold_nxt;
            r_lock    <= w_lock_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_valid = |r_grant;
    assign grant_id    = r_id;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sync_rr_arbiter
//   Directed bench for sync_rr_arbiter (NUM_REQ=4, MAX_HOLD=16). Inputs are
//   driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sync_rr_arbiter;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [3:0] async_req = 4'b0000;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    sync_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(16)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .async_req   (async_req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        n_rst     = 1'b0;
        async_req = 4'b0000;
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        n_rst     = 1'b0;
        async_req = 4'b1111;
        repeat (3) @(negedge clk);
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
        n_chk++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gv got %b want 0", grant_valid); end
        n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", grant_id); end
        n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
        n_rst = 1'b1;
        @(negedge clk);
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL post_reset_grant got %b want 0000", grant); end
        n_chk++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_gv got %b want 0", grant_valid); end
        n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL post_reset_id got %0d want 0", grant_id); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single();
        logic [3:0] exp;
        do_reset();
        @(negedge clk);
        async_req = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            exp = (k == 3) ? 4'b0100 : 4'b0000;
            n_chk++;
            if (grant !== exp) begin n_fail++; $display("FAIL single_rise edge=%0d got %b want %b", k, grant, exp); end
        end
        n_chk++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_id got %0d want 2", grant_id); end
        n_chk++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL single_gv got %b want 1", grant_valid); end
        async_req = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp = (k < 3) ? 4'b0100 : 4'b0000;
            n_chk++;
            if (grant !== exp) begin n_fail++; $display("FAIL single_fall edge=%0d got %b want %b", k, grant, exp); end
        end
        n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL single_timeout got %b want 0", timeout); end
        n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_idle_id got %0d want 0", grant_id); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_fairness();
        int         order [5] = '{0, 1, 2, 3, 0};
        int         n_g  = 0;
        int         held = 0;
        logic [3:0] prev = 4'b0000;
        logic [3:0] exp;
        do_reset();
        async_req = 4'b1111;
        for (int cyc = 0; cyc < 300 && n_g < 5; cyc++) begin
            @(negedge clk);
            n_chk++;
            if (!$onehot0(grant)) begin n_fail++; $display("FAIL fair_onehot got %b", grant); end
            n_chk++;
            if (grant != 4'b0000 && prev != 4'b0000 && grant != prev) begin
                n_fail++; $display("FAIL fair_gap got %b after %b want a zero cycle between", grant, prev);
            end
            if (grant != 4'b0000 && prev == 4'b0000) begin
                exp = 4'b0001 << order[n_g];
                n_chk++;
                if (grant !== exp || grant_id !== 2'(order[n_g])) begin
                    n_fail++; $display("FAIL fair_order n=%0d got %b id=%0d want %b id=%0d", n_g, grant, grant_id, exp, order[n_g]);
                end
                n_g++;
                held = 0;
            end
            if (grant != 4'b0000) begin
                held++;
                if (held == 3) async_req[grant_id] = 1'b0;
            end
            if (grant == 4'b0000 && prev != 4'b0000) async_req = 4'b1111;
            prev = grant;
        end
        n_chk++;
        if (n_g < 5) begin n_fail++; $display("FAIL fair_count got %0d grants want 5", n_g); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_timeout();
        int hi  = 0;
        bit ok  = 0;
        bit bad = 0;
        do_reset();
        async_req = 4'b0001;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (grant === 4'b0001) ok = 1;
        end
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL to_first_grant got %b want 0001", grant); end
        while (grant === 4'b0001 && hi < 40) begin
            hi++;
            @(negedge clk);
        end
        n_chk++; if (hi != 16) begin n_fail++; $display("FAIL to_hold_len got %0d want 16", hi); end
        n_chk++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_pulse got %b want 1", timeout); end
        @(negedge clk);
        n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width got %b want 0", timeout); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (grant !== 4'b0000) bad = 1;
        end
        n_chk++; if (bad) begin n_fail++; $display("FAIL to_locked got regrant want 0000 while held"); end
        async_req = 4'b0000;
        repeat (4) @(negedge clk);
        async_req = 4'b0001;
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (grant === 4'b0001) ok = 1;
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL to_regrant got %b want 0001 after re-raise", grant); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_rotation();
        logic [3:0] first_g = 4'b0000;
        logic [3:0] next_g  = 4'b0000;
        bit         seen_to = 0;
        bit         bad     = 0;
        do_reset();
        async_req = 4'b0011;
        for (int k = 0; k < 40 && !seen_to; k++) begin
            @(negedge clk);
            if (first_g == 4'b0000 && grant != 4'b0000) first_g = grant;
            if (timeout === 1'b1) seen_to = 1;
        end
        n_chk++; if (first_g !== 4'b0001) begin n_fail++; $display("FAIL rot_first got %b want 0001", first_g); end
        n_chk++; if (!seen_to) begin n_fail++; $display("FAIL rot_timeout got none want pulse"); end
        for (int k = 0; k < 10 && next_g == 4'b0000; k++) begin
            @(negedge clk);
            next_g = grant;
        end
        n_chk++; if (next_g !== 4'b0010) begin n_fail++; $display("FAIL rot_next got %b want 0010", next_g); end
        async_req = 4'b0001;
        for (int k = 0; k < 10 && grant != 4'b0000; k++) @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (grant !== 4'b0000) bad = 1;
        end
        n_chk++; if (bad) begin n_fail++; $display("FAIL rot_locked got regrant want 0000 while req0 locked"); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_meta();
        logic [1:0] pid = 2'd0;
        logic       pgv = 1'b0;
        bit         ok  = 0;
        do_reset();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_chk++;
            if ($isunknown({grant, grant_valid, grant_id, timeout})) begin
                n_fail++; $display("FAIL meta_x cyc=%0d got grant=%b gv=%b id=%b want no X", k, grant, grant_valid, grant_id);
            end
            n_chk++;
            if (!$onehot0(grant)) begin n_fail++; $display("FAIL meta_onehot cyc=%0d got %b", k, grant); end
            n_chk++;
            if (grant_valid !== (|grant)) begin n_fail++; $display("FAIL meta_gv cyc=%0d got %b want %b", k, grant_valid, |grant); end
            n_chk++;
            if (pgv && grant_valid && grant_id !== pid) begin
                n_fail++; $display("FAIL meta_id_stable cyc=%0d got %0d want %0d", k, grant_id, pid);
            end
            pgv = grant_valid;
            pid = grant_id;
            if (k % 4 == 0)      async_req = 4'bxxxx;
            else if (k % 4 == 1) async_req = 4'($urandom);
        end
        do_reset();
        async_req = 4'b0100;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (grant === 4'b0100) ok = 1;
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL meta_pre_rst got %b want 0100", grant); end
        #2 n_rst = 1'b0;
        #1;
        n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL async_rst_grant got %b want 0000", grant); end
        n_chk++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_gv got %b want 0", grant_valid); end
        n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL async_rst_id got %0d want 0", grant_id); end
        @(negedge clk);
        n_rst     = 1'b1;
        async_req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_rotation();
        test_meta();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
